// File: rtl/pin_entry_controller_pkg.sv
// Shared types and constants for the ATM card/PIN entry controller.
package pin_entry_controller_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEnter,
        StCheck,
        StGranted,
        StLocked
    } state_e;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;

    localparam int unsigned PIN_W = 16;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/pin_entry_controller_if.sv
// Request/response bus between the PIN entry controller and the authenticator.
interface pin_entry_controller_if;
    import pin_entry_controller_pkg::*;

    logic [3:0]       auth_acc_num;
    logic [PIN_W-1:0] auth_pin;
    logic             auth_req;
    logic             acc_found_stat;
    logic             acc_auth_stat;

    modport master (
        output auth_acc_num,
        output auth_pin,
        output auth_req,
        input  acc_found_stat,
        input  acc_auth_stat
    );

    modport slave (
        input  auth_acc_num,
        input  auth_pin,
        input  auth_req,
        output acc_found_stat,
        output acc_auth_stat
    );

endinterface

// File: rtl/pin_entry_controller_shift.sv
// BCD PIN shift register with digit counter; first key ends up in the top nibble.
module pin_shift_buffer #(
    parameter int unsigned PIN_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_shift,
    input  logic                    i_clear,
    input  logic [3:0]              i_digit,
    output logic [4*PIN_DIGITS-1:0] o_buf,
    output logic [2:0]              o_count,
    output logic                    o_full
);

    logic [4*PIN_DIGITS-1:0] r_buf;
    logic [2:0]              r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (i_shift) begin
            r_buf   <= {r_buf[4*PIN_DIGITS-5:0], i_digit};
            r_count <= r_count + 3'd1;
        end
    end

    assign o_buf   = r_buf;
    assign o_count = r_count;
    assign o_full  = (r_count == 3'(PIN_DIGITS));

endmodule

// File: rtl/pin_entry_controller.sv
// ATM card/PIN session controller: collects a PIN, queries the authenticator, tracks retries.
module pin_entry_controller
    import pin_entry_controller_pkg::*;
#(
    parameter int unsigned PIN_DIGITS   = 4,
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned TIMEOUT_CYC  = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_card_inserted,
    input  logic [3:0]                    i_card_acc_num,
    input  logic                          i_key_valid,
    input  logic [3:0]                    i_key_code,
    pin_entry_controller_if.master        auth_bus,
    output logic                          o_session_ok,
    output logic                          o_card_eject,
    output logic                          o_card_retained,
    output logic                          o_err_not_found,
    output logic                          o_err_bad_pin,
    output logic                          o_err_timeout,
    output logic [1:0]                    o_attempts_left,
    output logic [2:0]                    o_digit_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    state_e                  r_state, w_state_d;
    logic [3:0]              r_acc, w_acc_d;
    logic [1:0]              r_attempts, w_attempts_d;
    logic [TW-1:0]           r_timer, w_timer_d;
    logic                    r_eject, w_eject_d;
    logic                    r_not_found, w_not_found_d;
    logic                    r_bad_pin, w_bad_pin_d;
    logic                    r_timeout, w_timeout_d;

    logic                    w_shift, w_clear, w_full;
    logic [4*PIN_DIGITS-1:0] w_buf;
    logic [2:0]              w_count;

    pin_shift_buffer #(
        .PIN_DIGITS (PIN_DIGITS)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .i_digit (i_key_code),
        .o_buf   (w_buf),
        .o_count (w_count),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_attempts  <= '0;
            r_timer     <= '0;
            r_eject     <= 1'b0;
            r_not_found <= 1'b0;
            r_bad_pin   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_acc       <= w_acc_d;
            r_attempts  <= w_attempts_d;
            r_timer     <= w_timer_d;
            r_eject     <= w_eject_d;
            r_not_found <= w_not_found_d;
            r_bad_pin   <= w_bad_pin_d;
            r_timeout   <= w_timeout_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_acc_d       = r_acc;
        w_attempts_d  = r_attempts;
        w_timer_d     = r_timer;
        w_eject_d     = 1'b0;
        w_not_found_d = 1'b0;
        w_bad_pin_d   = 1'b0;
        w_timeout_d   = 1'b0;
        w_shift       = 1'b0;
        w_clear       = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_clear = 1'b1;
                if (i_card_inserted) begin
                    w_acc_d      = i_card_acc_num;
                    w_attempts_d = 2'(MAX_ATTEMPTS);
                    w_timer_d    = '0;
                    w_state_d    = StEnter;
                end
            end
            StEnter: begin
                // Card removal wins over any key seen in the same cycle.
                if (!i_card_inserted) begin
                    w_clear   = 1'b1;
                    w_state_d = StIdle;
                end else if (i_key_valid) begin
                    w_timer_d = '0;
                    if (is_digit(i_key_code)) begin
                        w_shift = !w_full;
                    end else if (i_key_code == KEY_CLEAR) begin
                        w_clear = 1'b1;
                    end else if (i_key_code == KEY_CANCEL) begin
                        w_eject_d = 1'b1;
                        w_clear   = 1'b1;
                        w_state_d = StIdle;
                    end else if (i_key_code == KEY_ENTER && w_full) begin
                        w_state_d = StCheck;
                    end
                end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                    w_timeout_d = 1'b1;
                    w_eject_d   = 1'b1;
                    w_clear     = 1'b1;
                    w_state_d   = StIdle;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StCheck: begin
                if (!i_card_inserted) begin
                    w_clear   = 1'b1;
                    w_state_d = StIdle;
                end else if (!auth_bus.acc_found_stat) begin
                    w_not_found_d = 1'b1;
                    w_eject_d     = 1'b1;
                    w_clear       = 1'b1;
                    w_state_d     = StIdle;
                end else if (auth_bus.acc_auth_stat) begin
                    w_state_d = StGranted;
                end else begin
                    w_attempts_d = r_attempts - 1'b1;
                    w_clear      = 1'b1;
                    if (r_attempts == 2'd1) begin
                        w_state_d = StLocked;
                    end else begin
                        w_bad_pin_d = 1'b1;
                        w_timer_d   = '0;
                        w_state_d   = StEnter;
                    end
                end
            end
            StGranted: begin
                if (!i_card_inserted) begin
                    w_clear   = 1'b1;
                    w_state_d = StIdle;
                end else if (i_key_valid && i_key_code == KEY_CANCEL) begin
                    w_eject_d = 1'b1;
                    w_clear   = 1'b1;
                    w_state_d = StIdle;
                end
            end
            StLocked: begin
                w_clear = 1'b1;
            end
            default: begin
                w_clear   = 1'b1;
                w_state_d = StIdle;
            end
        endcase
    end

    // The PIN and account are only driven onto the bus during the one CHECK cycle.
    assign auth_bus.auth_req     = (r_state == StCheck);
    assign auth_bus.auth_acc_num = (r_state == StCheck) ? r_acc : 4'd0;
    assign auth_bus.auth_pin     = (r_state == StCheck) ? PIN_W'(w_buf) : '0;

    assign o_session_ok    = (r_state == StGranted);
    assign o_card_retained = (r_state == StLocked);
    assign o_card_eject    = r_eject;
    assign o_err_not_found = r_not_found;
    assign o_err_bad_pin   = r_bad_pin;
    assign o_err_timeout   = r_timeout;
    assign o_attempts_left = r_attempts;
    assign o_digit_count   = w_count;

endmodule

// File: tb/tb_pin_entry_controller.sv
// Directed bench for pin_entry_controller with a stubbed authenticator.
module tb_pin_entry_controller;
    import pin_entry_controller_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       card_inserted;
    logic [3:0] card_acc_num;
    logic       key_valid;
    logic [3:0] key_code;
    logic       session_ok, card_eject, card_retained;
    logic       err_not_found, err_bad_pin, err_timeout;
    logic [1:0] attempts_left;
    logic [2:0] digit_count;

    int n_vec = 0;
    int n_err = 0;

    pin_entry_controller_if u_if ();

    pin_entry_controller #(
        .PIN_DIGITS   (4),
        .MAX_ATTEMPTS (3),
        .TIMEOUT_CYC  (1000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_card_inserted (card_inserted),
        .i_card_acc_num  (card_acc_num),
        .i_key_valid     (key_valid),
        .i_key_code      (key_code),
        .auth_bus        (u_if),
        .o_session_ok    (session_ok),
        .o_card_eject    (card_eject),
        .o_card_retained (card_retained),
        .o_err_not_found (err_not_found),
        .o_err_bad_pin   (err_bad_pin),
        .o_err_timeout   (err_timeout),
        .o_attempts_left (attempts_left),
        .o_digit_count   (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic enter_pin(input logic [3:0] a, b, c, d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_eject"}, 32'(card_eject), 32'd0);
        check({tag, "_nf"}, 32'(err_not_found), 32'd0);
        check({tag, "_bad"}, 32'(err_bad_pin), 32'd0);
        check({tag, "_to"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        card_inserted    = 1'b0;
        card_acc_num     = 4'd0;
        key_valid        = 1'b0;
        key_code         = 4'd0;
        u_if.acc_found_stat = 1'b1;
        u_if.acc_auth_stat  = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_req", 32'(u_if.auth_req), 32'd0);
        check("rst_pin", 32'(u_if.auth_pin), 32'd0);
        check("rst_att", 32'(attempts_left), 32'd0);
        check("rst_cnt", 32'(digit_count), 32'd0);
        check("rst_ok", 32'(session_ok), 32'd0);
        check_quiet("rst");
        rst_n = 1'b1;
        tick();

        // 1: good PIN 1234, account 3
        card_inserted = 1'b1;
        card_acc_num  = 4'd3;
        tick();
        check("t1_att", 32'(attempts_left), 32'd3);
        enter_pin(4'd1, 4'd2, 4'd3, 4'd4);
        check("t1_cnt", 32'(digit_count), 32'd4);
        check("t1_pin_hidden", 32'(u_if.auth_pin), 32'd0);
        press(KEY_ENTER);
        check("t1_req", 32'(u_if.auth_req), 32'd1);
        check("t1_pin", 32'(u_if.auth_pin), 32'h1234);
        check("t1_acc", 32'(u_if.auth_acc_num), 32'd3);
        check("t1_ok_early", 32'(session_ok), 32'd0);
        tick();
        check("t1_ok", 32'(session_ok), 32'd1);
        check("t1_req_off", 32'(u_if.auth_req), 32'd0);
        check("t1_pin_off", 32'(u_if.auth_pin), 32'd0);
        press(KEY_CANCEL);
        card_inserted = 1'b0;
        check("t1_eject", 32'(card_eject), 32'd1);
        check("t1_ok_off", 32'(session_ok), 32'd0);
        tick();
        check("t1_eject_end", 32'(card_eject), 32'd0);

        // 2: short ENTER ignored, extra digit dropped
        card_inserted = 1'b1;
        card_acc_num  = 4'd5;
        tick();
        press(4'd5);
        press(4'd6);
        press(KEY_ENTER);
        check("t2_short_req", 32'(u_if.auth_req), 32'd0);
        check("t2_short_cnt", 32'(digit_count), 32'd2);
        press(4'd7);
        press(4'd8);
        press(4'd9);
        check("t2_full_cnt", 32'(digit_count), 32'd4);
        press(4'hE);
        press(KEY_ENTER);
        check("t2_req", 32'(u_if.auth_req), 32'd1);
        check("t2_pin", 32'(u_if.auth_pin), 32'h5678);
        tick();
        check("t2_ok", 32'(session_ok), 32'd1);
        card_inserted = 1'b0;
        tick();
        check("t2_removed_ok", 32'(session_ok), 32'd0);
        check_quiet("t2_removed");

        // 3: three wrong PINs -> retained
        card_inserted       = 1'b1;
        card_acc_num        = 4'd6;
        u_if.acc_auth_stat  = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            enter_pin(4'd1, 4'd1, 4'd1, 4'd1);
            press(KEY_ENTER);
            tick();
            check("t3_att", 32'(attempts_left), 32'(2 - i));
            check("t3_bad", 32'(err_bad_pin), (i < 2) ? 32'd1 : 32'd0);
            check("t3_ret", 32'(card_retained), (i == 2) ? 32'd1 : 32'd0);
            check("t3_cnt", 32'(digit_count), 32'd0);
        end
        card_inserted = 1'b0;
        press(KEY_CANCEL);
        tick();
        check("t3_ret_hold", 32'(card_retained), 32'd1);
        check("t3_no_eject", 32'(card_eject), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t3_ret_rst", 32'(card_retained), 32'd0);
        rst_n = 1'b1;
        u_if.acc_auth_stat = 1'b1;
        tick();

        // 4: unknown account
        card_inserted       = 1'b1;
        card_acc_num        = 4'd9;
        u_if.acc_found_stat = 1'b0;
        tick();
        enter_pin(4'd2, 4'd4, 4'd6, 4'd8);
        press(KEY_ENTER);
        check("t4_acc", 32'(u_if.auth_acc_num), 32'd9);
        tick();
        card_inserted = 1'b0;
        check("t4_nf", 32'(err_not_found), 32'd1);
        check("t4_eject", 32'(card_eject), 32'd1);
        check("t4_cnt", 32'(digit_count), 32'd0);
        tick();
        check("t4_nf_end", 32'(err_not_found), 32'd0);
        check("t4_ok", 32'(session_ok), 32'd0);
        u_if.acc_found_stat = 1'b1;

        // 5a: inactivity timeout after exactly TIMEOUT_CYC idle cycles
        card_inserted = 1'b1;
        tick();
        press(4'd1);
        press(4'd2);
        repeat (999) tick();
        check("t5_no_to_999", 32'(err_timeout), 32'd0);
        tick();
        check("t5_to", 32'(err_timeout), 32'd1);
        check("t5_eject", 32'(card_eject), 32'd1);
        card_inserted = 1'b0;
        tick();
        check("t5_to_end", 32'(err_timeout), 32'd0);

        // 5b: CLEAR on the last idle cycle restarts the timer
        card_inserted = 1'b1;
        tick();
        press(4'd1);
        press(4'd2);
        repeat (999) tick();
        press(KEY_CLEAR);
        check("t5b_no_to", 32'(err_timeout), 32'd0);
        check("t5b_no_eject", 32'(card_eject), 32'd0);
        check("t5b_cnt", 32'(digit_count), 32'd0);
        repeat (999) tick();
        check("t5b_no_to_999", 32'(err_timeout), 32'd0);
        tick();
        check("t5b_to", 32'(err_timeout), 32'd1);
        card_inserted = 1'b0;
        tick();

        // 6a: reset asserted during CHECK
        card_inserted = 1'b1;
        card_acc_num  = 4'd3;
        tick();
        enter_pin(4'd4, 4'd3, 4'd2, 4'd1);
        press(KEY_ENTER);
        check("t6a_req", 32'(u_if.auth_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6a_req_off", 32'(u_if.auth_req), 32'd0);
        check("t6a_pin", 32'(u_if.auth_pin), 32'd0);
        check("t6a_cnt", 32'(digit_count), 32'd0);
        check_quiet("t6a");
        card_inserted = 1'b0;
        rst_n = 1'b1;
        tick();

        // 6b: card removed in the same cycle as ENTER
        card_inserted = 1'b1;
        tick();
        enter_pin(4'd1, 4'd2, 4'd3, 4'd4);
        key_valid     = 1'b1;
        key_code      = KEY_ENTER;
        card_inserted = 1'b0;
        tick();
        key_valid = 1'b0;
        check("t6b_req", 32'(u_if.auth_req), 32'd0);
        check("t6b_pin", 32'(u_if.auth_pin), 32'd0);
        check("t6b_cnt", 32'(digit_count), 32'd0);
        check_quiet("t6b");
        tick();
        check("t6b_req_late", 32'(u_if.auth_req), 32'd0);
        check("t6b_ok", 32'(session_ok), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
